// File: rtl/controle_multiciclo_if.sv
// Bus between the multicycle control unit and the datapath it sequences.
// The control unit is the slave side; the datapath (or a bench) drives opcode/zero/pc.
interface controle_multiciclo_if;
   logic [6:0]  opcode;
   logic        zero;
   logic [31:0] pc;

   logic [3:0]  estado;
   logic        pc_escreve;
   logic        pc_escreve_cond;
   logic        pc_fonte;
   logic        ula_fonte_b;
   logic [1:0]  ula_op;
   logic        mem_le;
   logic        mem_escreve;
   logic        mem_para_reg;
   logic        reg_escreve;
   logic        parado;
   logic        erro;
   logic [31:0] ciclos;
   logic [31:0] instr_ret;

   // Combined PC load enable: a taken branch only loads when the ALU reports equality.
   logic        pc_carrega;
   assign pc_carrega = pc_escreve | (pc_escreve_cond & zero);

   modport slave (
      input  opcode, zero, pc,
      output estado, pc_escreve, pc_escreve_cond, pc_fonte, ula_fonte_b, ula_op,
             mem_le, mem_escreve, mem_para_reg, reg_escreve, parado, erro,
             ciclos, instr_ret
   );

   modport master (
      output opcode, zero, pc,
      input  estado, pc_escreve, pc_escreve_cond, pc_fonte, ula_fonte_b, ula_op,
             mem_le, mem_escreve, mem_para_reg, reg_escreve, parado, erro,
             ciclos, instr_ret, pc_carrega
   );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for an RV32I subset (R-ALU, I-ALU, lw, sw, beq).
// Moore controls decoded from the state; halts past the program end and counts cycles/retirements.
module controle_multiciclo #(
   parameter int unsigned NUM_INSTR = 15,
   parameter int unsigned PC_INC    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   controle_multiciclo_if.slave bus
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      EXEC_R    = 4'd2,
      EXEC_I    = 4'd3,
      MEM_ADDR  = 4'd4,
      MEM_READ  = 4'd5,
      MEM_WB    = 4'd6,
      MEM_WRITE = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9,
      HALT      = 4'd10,
      ERRO      = 4'd11
   } estado_t;

   localparam logic [6:0] OP_R_ALU = 7'b0110011;
   localparam logic [6:0] OP_I_ALU = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] ULA_ADD  = 2'b00;
   localparam logic [1:0] ULA_SUB  = 2'b01;
   localparam logic [1:0] ULA_R    = 2'b10;
   localparam logic [1:0] ULA_I    = 2'b11;

   // PC advances PC_INC per instruction word, so the program ends at NUM_INSTR*PC_INC.
   localparam logic [31:0] PC_LIMITE = 32'(NUM_INSTR * PC_INC);

   estado_t     estado_q;
   estado_t     estado_d;
   logic [6:0]  opcode_r;
   logic [31:0] ciclos_q;
   logic [31:0] instr_ret_q;
   logic        fim_programa;
   logic        fim_instr;
   logic        vai_parar;

   logic        pc_escreve;
   logic        pc_escreve_cond;
   logic        pc_fonte;
   logic        ula_fonte_b;
   logic [1:0]  ula_op;
   logic        mem_le;
   logic        mem_escreve;
   logic        mem_para_reg;
   logic        reg_escreve;
   logic        parado;
   logic        erro;

   assign fim_programa = (bus.pc >= PC_LIMITE);
   assign fim_instr    = (estado_q == MEM_WB) || (estado_q == MEM_WRITE) ||
                         (estado_q == ALU_WB) || (estado_q == BRANCH);
   assign vai_parar    = (estado_d == HALT) || (estado_d == ERRO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= FETCH;
      end else begin
         estado_q <= estado_d;
      end
   end

   // Opcode is only guaranteed valid in DECODE; MEM_ADDR steers lw/sw from this copy.
   always_ff @(posedge clk) begin
      if (estado_q == DECODE) begin
         opcode_r <= bus.opcode;
      end
   end

   always_comb begin
      estado_d = ERRO;
      case (estado_q)
         FETCH:     estado_d = fim_programa ? HALT : DECODE;
         DECODE: begin
            case (bus.opcode)
               OP_R_ALU:     estado_d = EXEC_R;
               OP_I_ALU:     estado_d = EXEC_I;
               OP_LW, OP_SW: estado_d = MEM_ADDR;
               OP_BEQ:       estado_d = BRANCH;
               default:      estado_d = ERRO;
            endcase
         end
         EXEC_R:    estado_d = ALU_WB;
         EXEC_I:    estado_d = ALU_WB;
         MEM_ADDR:  estado_d = (opcode_r == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ:  estado_d = MEM_WB;
         MEM_WB:    estado_d = FETCH;
         MEM_WRITE: estado_d = FETCH;
         ALU_WB:    estado_d = FETCH;
         BRANCH:    estado_d = FETCH;
         HALT:      estado_d = HALT;
         ERRO:      estado_d = ERRO;
         default:   estado_d = ERRO;
      endcase
   end

   // Controls are forced low while rst_n is asserted so no strobe survives an abort.
   always_comb begin
      pc_escreve      = 1'b0;
      pc_escreve_cond = 1'b0;
      pc_fonte        = 1'b0;
      ula_fonte_b     = 1'b0;
      ula_op          = ULA_ADD;
      mem_le          = 1'b0;
      mem_escreve     = 1'b0;
      mem_para_reg    = 1'b0;
      reg_escreve     = 1'b0;
      parado          = 1'b0;
      erro            = 1'b0;
      if (rst_n) begin
         case (estado_q)
            FETCH:     pc_escreve = !fim_programa;
            EXEC_R: begin
               ula_op      = ULA_R;
               ula_fonte_b = 1'b0;
            end
            EXEC_I: begin
               ula_op      = ULA_I;
               ula_fonte_b = 1'b1;
            end
            MEM_ADDR: begin
               ula_op      = ULA_ADD;
               ula_fonte_b = 1'b1;
            end
            MEM_READ:  mem_le = 1'b1;
            MEM_WB: begin
               reg_escreve  = 1'b1;
               mem_para_reg = 1'b1;
            end
            MEM_WRITE: mem_escreve = 1'b1;
            ALU_WB:    reg_escreve = 1'b1;
            BRANCH: begin
               ula_op          = ULA_SUB;
               ula_fonte_b     = 1'b0;
               pc_escreve_cond = 1'b1;
               pc_fonte        = 1'b1;
            end
            HALT:      parado = 1'b1;
            ERRO: begin
               parado = 1'b1;
               erro   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // The cycle that moves into HALT/ERRO is already excluded from ciclos.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ciclos_q    <= 32'd0;
         instr_ret_q <= 32'd0;
      end else begin
         if (!vai_parar) begin
            ciclos_q <= ciclos_q + 32'd1;
         end
         if (fim_instr) begin
            instr_ret_q <= instr_ret_q + 32'd1;
         end
      end
   end

   assign bus.estado          = estado_q;
   assign bus.pc_escreve      = pc_escreve;
   assign bus.pc_escreve_cond = pc_escreve_cond;
   assign bus.pc_fonte        = pc_fonte;
   assign bus.ula_fonte_b     = ula_fonte_b;
   assign bus.ula_op          = ula_op;
   assign bus.mem_le          = mem_le;
   assign bus.mem_escreve     = mem_escreve;
   assign bus.mem_para_reg    = mem_para_reg;
   assign bus.reg_escreve     = reg_escreve;
   assign bus.parado          = parado;
   assign bus.erro            = erro;
   assign bus.ciclos          = ciclos_q;
   assign bus.instr_ret       = instr_ret_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: random programs run against an instruction-level model
// (state sequence per instruction class, counters by plain arithmetic), plus directed reset cases.
module tb_controle_multiciclo;

   localparam int NI = 15;
   localparam logic [6:0] R_OP = 7'b0110011;
   localparam logic [6:0] I_OP = 7'b0010011;
   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] BEQ  = 7'b1100011;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;
   logic [6:0] prog [16];

   controle_multiciclo_if bus ();

   controle_multiciclo dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [11:0] ctl_obs;
   assign ctl_obs = {bus.pc_escreve, bus.pc_escreve_cond, bus.pc_fonte, bus.ula_fonte_b,
                     bus.ula_op, bus.mem_le, bus.mem_escreve, bus.mem_para_reg,
                     bus.reg_escreve, bus.parado, bus.erro};

   // {pc_escreve, pc_escreve_cond, pc_fonte, ula_fonte_b, ula_op, mem_le, mem_escreve,
   //  mem_para_reg, reg_escreve, parado, erro} required in each state
   function automatic logic [11:0] ctl_ref(input int st, input bit pc_ok);
      case (st)
         0:       return pc_ok ? 12'b1000_0000_0000 : 12'b0;
         2:       return 12'b0000_1000_0000;
         3:       return 12'b0001_1100_0000;
         4:       return 12'b0001_0000_0000;
         5:       return 12'b0000_0010_0000;
         6:       return 12'b0000_0000_1100;
         7:       return 12'b0000_0001_0000;
         8:       return 12'b0000_0000_0100;
         9:       return 12'b0110_0100_0000;
         10:      return 12'b0000_0000_0010;
         11:      return 12'b0000_0000_0011;
         default: return 12'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3 rst_n = 1'b0;
      bus.pc = 32'd0; bus.opcode = 7'd0; bus.zero = 1'b0;
      #1;
      chk("rst_estado", bus.estado, 0);
      chk("rst_ctl", ctl_obs, 0);
      chk("rst_ciclos", bus.ciclos, 0);
      chk("rst_instr_ret", bus.instr_ret, 0);
      @(posedge clk); #1;
      chk("rst_hold_estado", bus.estado, 0);
      chk("rst_hold_ctl", ctl_obs, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic gen_prog();
      logic [6:0] bad [4];
      bad[0] = 7'h7F; bad[1] = 7'h00; bad[2] = 7'h6F; bad[3] = 7'h37;
      for (int i = 0; i < 16; i++) begin
         int r;
         r = $urandom_range(0, 20);
         if (r < 4)       prog[i] = R_OP;
         else if (r < 8)  prog[i] = I_OP;
         else if (r < 12) prog[i] = LW;
         else if (r < 16) prog[i] = SW;
         else if (r < 20) prog[i] = BEQ;
         else             prog[i] = bad[$urandom_range(0, 3)];
      end
   endtask

   // Datapath stand-in plus instruction-level reference: each instruction expands to its
   // state sequence; stop: 0 running, 1 halted, 2 error. pend is the stop the plan ends in.
   task automatic run_prog(input int budget);
      int pc, st, stop, pend, m_cyc, m_ret;
      int plan[$];
      logic [6:0] ir;
      logic z;
      pc = 0; stop = 0; pend = 0; m_cyc = 0; m_ret = 0; ir = 7'd0;
      plan.delete();
      do_reset();
      for (int c = 0; c < budget; c++) begin
         if (stop == 0 && plan.size() == 0) begin
            if (pc >= NI) begin
               plan = {0}; pend = 1;
            end else begin
               case (prog[pc])
                  R_OP:    plan = {0, 1, 2, 8};
                  I_OP:    plan = {0, 1, 3, 8};
                  LW:      plan = {0, 1, 4, 5, 6};
                  SW:      plan = {0, 1, 4, 7};
                  BEQ:     plan = {0, 1, 9};
                  default: begin plan = {0, 1}; pend = 2; end
               endcase
            end
         end
         st = (stop == 1) ? 10 : (stop == 2) ? 11 : plan[0];
         z  = 1'($urandom);
         bus.pc     = 32'(pc);
         bus.zero   = z;
         bus.opcode = (st == 1) ? ir : 7'($urandom);
         #1;
         chk("estado", bus.estado, st);
         chk("ctl", ctl_obs, ctl_ref(st, pc < NI));
         chk("ciclos", bus.ciclos, m_cyc);
         chk("instr_ret", bus.instr_ret, m_ret);
         @(posedge clk);
         if (stop == 0) begin
            if (st == 0 && pc < NI) begin
               ir = prog[pc];
               pc = pc + 1;
            end
            if (st == 9 && z) pc = pc + $urandom_range(0, 2);
            if (st == 6 || st == 7 || st == 8 || st == 9) m_ret++;
            void'(plan.pop_front());
            if (plan.size() == 0 && pend != 0) begin
               stop = pend; pend = 0;
            end else begin
               m_cyc++;
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      bus.pc = 32'd0; bus.opcode = 7'd0; bus.zero = 1'b0;

      // straight-line ALU program running into the halt
      for (int i = 0; i < 16; i++) prog[i] = R_OP;
      run_prog(70);

      for (int p = 0; p < 10; p++) begin
         gen_prog();
         run_prog(120);
      end

      // illegal first instruction, then the next reset must clear everything
      gen_prog();
      prog[0] = 7'b1111111;
      run_prog(8);
      prog[0] = SW; prog[1] = LW; prog[2] = BEQ;
      run_prog(20);

      // abort in the middle of a load: no writeback may follow
      do_reset();
      bus.pc = 32'd0; bus.opcode = LW;
      k = 0;
      while (k < 10 && bus.estado != 4'd5) begin
         @(negedge clk); k++;
      end
      chk("reach_mem_read", bus.estado, 5);
      chk("mem_le_before_abort", bus.mem_le, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_estado", bus.estado, 0);
      chk("abort_mem_le", bus.mem_le, 0);
      chk("abort_ctl", ctl_obs, 0);
      chk("abort_ciclos", bus.ciclos, 0);
      @(posedge clk); #1;
      chk("abort_no_wb", bus.reg_escreve, 0);
      chk("abort_instr_ret", bus.instr_ret, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("after_abort_estado", bus.estado, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
